key_event_detect: RTL and testbench

//  Multi-channel push-button conditioner on the board clock domain.
//  - Synchronises raw key pins, debounces them, emits single-cycle press/release/long-press events.
//  - Sits directly upstream of the LED-mode/user-control logic in top, replacing ad-hoc per-key delay counters.
//  - Consumers get glitch-free levels plus one-cycle strobes.

---
 rtl/key_event_pkg.sv | 30 +++
 rtl/key_event_chan.sv | 163 ++++++++++++++++
 rtl/key_event_detect.sv | 48 ++++
 tb/tb_key_event_detect.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_pkg
//  Description : Shared types and helpers for the key event conditioner:
//                per-channel state encoding and the counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_event_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } key_state_t;

    // Width of the shared per-channel counter: it never needs to hold more
    // than (largest terminal count - 1), so clog2 of the largest period is enough.
    function automatic int cnt_width(input int d, input int l, input int r);
        int m;
        m = d;
        if (l > m) m = l;
        if (r > m) m = r;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_chan.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_chan
//  Description : One push-button channel: 2-FF synchroniser, polarity
//                normalisation, debounce/hold FSM with one shared counter,
//                registered level and single-cycle event strobes.
//                Auto-repeat is built only when KEY_EVENT_REPEAT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_chan
    import key_event_pkg::*;
#(
    parameter int KEY_ACTIVE_HIGH = 1,
    parameter int DEBOUNCE_CYCLES = 8192,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic i_key,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);

    // Pin level that means "not pressed"; the synchroniser resets to it so
    // that leaving reset never looks like a press.
    localparam logic c_RELEASED = (KEY_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] c_REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic [1:0]       r_sync;
    logic             w_act;
    key_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_long_flag;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_long;
`ifdef KEY_EVENT_REPEAT_EN
    logic             r_repeat;
`endif

    // Two-stage synchroniser for the asynchronous key pin.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {2{c_RELEASED}};
        end else begin
            r_sync <= {r_sync[0], i_key};
        end
    end

    // Normalised activity: 1 whenever the synchronised pin reads "pressed".
    assign w_act = r_sync[1] ^ c_RELEASED;

    // Debounce / hold state machine with registered level and event strobes.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_long_flag <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
            r_repeat    <= 1'b0;
`endif
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
            r_repeat  <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_act) begin
                        r_state <= PRESS_DB;
                        r_cnt   <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!w_act) begin
                        r_state <= IDLE;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_state <= HELD;
                        r_press <= 1'b1;
                        r_level <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                HELD: begin
                    if (!w_act) begin
                        r_state <= RELEASE_DB;
                        r_cnt   <= '0;
                    end else if (!r_long_flag) begin
                        if (r_cnt == c_LONG_LAST) begin
                            r_long      <= 1'b1;
                            r_long_flag <= 1'b1;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
`ifdef KEY_EVENT_REPEAT_EN
                    else if (r_cnt == c_REP_LAST) begin
                        r_repeat <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
`endif
                    // Without auto-repeat the counter simply holds once the
                    // long press has been reported.
                end
                RELEASE_DB: begin
                    if (w_act) begin
                        // Bounce back: long timing restarts, flag is kept.
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_state     <= IDLE;
                        r_release   <= 1'b1;
                        r_level     <= 1'b0;
                        r_long_flag <= 1'b0;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
`ifdef KEY_EVENT_REPEAT_EN
    assign o_repeat  = r_repeat;
`else
    assign o_repeat  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/key_event_detect.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_detect
//  Description : Multi-channel push-button conditioner. Replicates one
//                key_event_chan per key; channels are fully independent.
//                Optional auto-repeat: define KEY_EVENT_REPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_detect #(
    parameter int N_KEYS          = 2,
    parameter int KEY_ACTIVE_HIGH = 1,
    parameter int DEBOUNCE_CYCLES = 8192,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat
);

    // One independent conditioner per key pin.
    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
            key_event_chan #(
                .KEY_ACTIVE_HIGH (KEY_ACTIVE_HIGH),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .LONG_CYCLES     (LONG_CYCLES),
                .REPEAT_CYCLES   (REPEAT_CYCLES)
            ) u_chan (
                .clk_50m   (clk_50m),
                .rst_n     (rst_n),
                .i_key     (key_in[gi]),
                .o_level   (key_level[gi]),
                .o_press   (key_press[gi]),
                .o_release (key_release[gi]),
                .o_long    (key_long[gi]),
                .o_repeat  (key_repeat[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_event_detect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event_detect
//  Description : Self-checking bench for key_event_detect. A run-length
//                reference model predicts every output on every clock;
//                directed steps check latencies and event counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_detect;

    localparam int D = 8;
    localparam int L = 40;
    localparam int R = 10;
`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic [1:0] key_in  = 2'b00;
    logic [1:0] key_level, key_press, key_release, key_long, key_repeat;

    int checks   = 0;
    int failures = 0;

    always #5 clk_50m = ~clk_50m;

    key_event_detect #(
        .N_KEYS          (2),
        .KEY_ACTIVE_HIGH (1),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_repeat  (key_repeat)
    );

    // Reference model: pin history, debounced level, length of the current
    // run of samples disagreeing with the level, and length of the current hold.
    logic [1:0] m_p1, m_p2;
    logic [1:0] m_level, m_press, m_release, m_long, m_repeat;
    int         m_run  [2];
    int         m_hold [2];
    bit         m_ldone[2];
    int n_press[2], n_release[2], n_long[2], n_repeat[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_p1 = 2'b00; m_p2 = 2'b00;
        m_level = 2'b00; m_press = 2'b00; m_release = 2'b00; m_long = 2'b00; m_repeat = 2'b00;
        for (int c = 0; c < 2; c++) begin
            m_run[c] = 0; m_hold[c] = 0; m_ldone[c] = 1'b0;
        end
    endtask

    // A change is accepted once D+1 consecutive synchronised samples disagree
    // with the current level; the synchroniser delays the pin by two clocks.
    task automatic model_step();
        logic [1:0] act;
        act  = m_p2;
        m_p2 = m_p1;
        m_p1 = key_in;
        m_press = 2'b00; m_release = 2'b00; m_long = 2'b00; m_repeat = 2'b00;
        for (int c = 0; c < 2; c++) begin
            if (!m_level[c]) begin
                m_run[c] = act[c] ? m_run[c] + 1 : 0;
                if (m_run[c] == D + 1) begin
                    m_level[c] = 1'b1; m_press[c] = 1'b1; m_run[c] = 0; m_hold[c] = 0;
                end
            end else if (!act[c]) begin
                m_run[c]++; m_hold[c] = 0;
                if (m_run[c] == D + 1) begin
                    m_level[c] = 1'b0; m_release[c] = 1'b1; m_run[c] = 0; m_ldone[c] = 1'b0;
                end
            end else if (m_run[c] > 0) begin
                m_run[c] = 0; m_hold[c] = 0;
            end else begin
                m_hold[c]++;
                if (!m_ldone[c] && m_hold[c] == L) begin
                    m_long[c] = 1'b1; m_ldone[c] = 1'b1; m_hold[c] = 0;
                end else if (m_ldone[c] && REP_EN && m_hold[c] == R) begin
                    m_repeat[c] = 1'b1; m_hold[c] = 0;
                end
            end
        end
    endtask

    // Advance one clock, update the model and compare every output.
    task automatic tick();
        @(posedge clk_50m);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check("cycle_outputs", {22'd0, key_level, key_press, key_release, key_long, key_repeat},
              {22'd0, m_level, m_press, m_release, m_long, m_repeat});
        for (int c = 0; c < 2; c++) begin
            n_press[c]   += int'(key_press[c]);
            n_release[c] += int'(key_release[c]);
            n_long[c]    += int'(key_long[c]);
            n_repeat[c]  += int'(key_repeat[c]);
        end
    endtask

    function automatic logic pulse_bit(input int kind, input int ch);
        case (kind)
            0:       return key_press[ch];
            1:       return key_release[ch];
            2:       return key_long[ch];
            default: return key_repeat[ch];
        endcase
    endfunction

    // Tick until the chosen pulse appears; lat = clocks taken, -1 on timeout.
    task automatic wait_for(input int kind, input int ch, input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (pulse_bit(kind, ch)) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int base;
        int long_at;
        int rep_q[$];
        int dur;

        for (int c = 0; c < 2; c++) begin
            n_press[c] = 0; n_release[c] = 0; n_long[c] = 0; n_repeat[c] = 0;
        end
        model_reset();

        // Reset, then 100 idle cycles with released pins.
        repeat (3) tick();
        check("reset_outputs", {22'd0, key_level, key_press, key_release, key_long, key_repeat}, 32'd0);
        rst_n = 1'b1;
        repeat (100) tick();
        check("idle_no_events", n_press[0] + n_press[1] + n_release[0] + n_release[1]
              + n_long[0] + n_long[1] + n_repeat[0] + n_repeat[1], 0);

        // Press latency, long press, hold, release bounce, release latency.
        key_in = 2'b01;
        wait_for(0, 0, 40, lat);
        check("press_latency", lat, 11);
        check("press_level", key_level, 2'b01);
        base = n_long[0];
        wait_for(2, 0, 80, lat);
        check("long_latency", lat, L);
        repeat (20) tick();
        check("long_single", n_long[0] - base, 1);
        key_in = 2'b00;
        repeat (3) tick();
        key_in = 2'b01;
        repeat (60) tick();
        check("no_second_long", n_long[0] - base, 1);
        check("level_after_bounce", key_level[0], 1'b1);
        key_in = 2'b00;
        wait_for(1, 0, 40, lat);
        check("release_latency", lat, 11);
        check("release_level", key_level, 2'b00);

        // Bouncy press: 5 active, 1 inactive, then active.
        base = n_press[0];
        key_in = 2'b01;
        repeat (5) tick();
        key_in = 2'b00;
        tick();
        key_in = 2'b01;
        wait_for(0, 0, 40, lat);
        check("bounce_latency", lat, 11);
        repeat (9) tick();
        check("bounce_one_press", n_press[0] - base, 1);
        key_in = 2'b00;
        wait_for(1, 0, 40, lat);
        check("bounce_release_latency", lat, 11);

        // 7-cycle glitch must be rejected.
        base = n_press[0];
        key_in = 2'b01;
        repeat (7) tick();
        key_in = 2'b00;
        repeat (20) tick();
        check("glitch_no_press", n_press[0] - base, 0);
        check("glitch_level", key_level, 2'b00);

        // Simultaneous presses, then key1 releases alone.
        key_in = 2'b11;
        wait_for(0, 0, 40, lat);
        check("dual_press_latency", lat, 11);
        check("dual_press_same_cycle", key_press, 2'b11);
        key_in = 2'b01;
        wait_for(1, 1, 40, lat);
        check("key1_release_latency", lat, 11);
        check("key0_still_held", key_level, 2'b01);
        key_in = 2'b00;
        wait_for(1, 0, 60, lat);
        check("key0_release_seen", lat > 0, 1'b1);

        // Long press followed by auto-repeat (or none without the feature).
        key_in = 2'b01;
        wait_for(0, 0, 40, lat);
        long_at = -1;
        for (int t = 1; t <= 80; t++) begin
            tick();
            if (key_long[0]) long_at = t;
            if (key_repeat[0]) rep_q.push_back(t);
        end
        check("repeat_long_at", long_at, L);
        check("repeat_count", rep_q.size(), REP_EN ? 4 : 0);
        for (int i = 0; i < rep_q.size(); i++) check("repeat_time", rep_q[i], L + R * (i + 1));
        key_in = 2'b00;
        wait_for(1, 0, 60, lat);
        check("repeat_release_seen", lat > 0, 1'b1);

        // Reset asserted while a key is held: level drops at once, no release.
        key_in = 2'b10;
        wait_for(0, 1, 40, lat);
        repeat (5) tick();
        base = n_release[1];
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_held_level", key_level, 2'b00);
        check("reset_mid_held_pulses", {key_press, key_release, key_long, key_repeat}, 8'd0);
        key_in = 2'b00;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("reset_no_release", n_release[1] - base, 0);

        // Randomised pin activity on both keys against the model.
        for (int s = 0; s < 40; s++) begin
            key_in = 2'($urandom_range(0, 3));
            dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : $urandom_range(1, 60);
            repeat (dur) tick();
        end
        key_in = 2'b00;
        repeat (30) tick();
        check("random_end_level", key_level, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
